udma_i2c_cmd_arbiter: RTL and testbench
=======================================

// Module: udma_i2c_cmd_arbiter
// PURPOSE
//  Shares one udma_i2c_control command/data channel among NB_REQ requesters (uDMA channels, HW sequencers).
//  Round-robin grant with bus lock: a grant is held from the first command until the owner's EOT command is accepted, or until an abort.
//  A watchdog and the controller error input force a STOP injection, so a dead requester cannot hold the I2C bus.
//  Sits between the requesters and udma_i2c_control (cmd, tx, rx, eot, err).
// PARAMETERS
//  NB_REQ      4     number of requesters (2..8)
//  TIMEOUT_CYC 1024  cycles the owner may stay silent while the controller idles before abort (>=2)
// PORTS
//  clk_i           in   1          clock
//  rst_i           in   1          synchronous active-high reset
//  req_cmd_i       in   NB_REQx32  per-requester command word, opcode in [31:28]
//  req_cmd_valid_i in   NB_REQ     command valid
//  req_cmd_ready_o out  NB_REQ     command accepted
//  req_tx_i        in   NB_REQx8   per-requester write data
//  req_tx_valid_i  in   NB_REQ     write data valid
//  req_tx_ready_o  out  NB_REQ     write data ready
//  req_rx_o        out  8          read data, broadcast to all requesters
//  req_rx_valid_o  out  NB_REQ     read data valid, owner only
//  req_rx_ready_i  in   NB_REQ     read data ready
//  req_eot_o       out  NB_REQ     end-of-transfer pulse to owner
//  req_abort_o     out  NB_REQ     1-cycle pulse: owner's session was aborted
//  cmd_o/cmd_valid_o/cmd_ready_i   32/1/1  to controller udma_cmd_*
//  tx_o/tx_valid_o/tx_ready_i      8/1/1   to controller data_tx_*
//  rx_i/rx_valid_i/rx_ready_o      8/1/1   from controller data_rx_*
//  eot_i           in   1          controller eot_o
//  err_i           in   1          controller err_o (busy/arbitration-lost pulse)
//  grant_o         out  NB_REQ     one-hot current owner, 0 when idle
// BEHAVIOUR
//  Reset: all outputs 0 (grant_o=0, cmd_valid_o=0, tx_valid_o=0, rx_ready_o=0); FSM=IDLE; rr_ptr=0; wd_cnt=0.
//  FSM IDLE -> GRANTED -> (IDLE | ABORT -> IDLE).
//  IDLE: if any req_cmd_valid_i, register the first valid index searching upward from rr_ptr, with wrap.
//    The grant is registered; the first forward happens the next cycle (1-cycle arbitration latency). No ready is given in IDLE.
//  GRANTED, owner g: cmd/tx/rx are combinationally muxed between g and the controller.
//    Non-owners see ready=0 and rx_valid=0. req_eot_o[g]=eot_i.
//  Release: on the cycle the owner's cmd with opcode I2C_CMD_EOT is accepted (valid&ready), next state IDLE, rr_ptr<=g+1 mod NB_REQ.
//    A new grant is possible the cycle after release; the same requester is eligible when it is the only one valid.
//  Watchdog: wd_cnt increments while GRANTED & cmd_ready_i & ~req_cmd_valid_i[g]; clears on any owner handshake (cmd/tx/rx).
//    Reaching TIMEOUT_CYC-1 -> ABORT. The count saturates and never wraps.
//  err_i in GRANTED -> ABORT in the next cycle. Watchdog and err_i in the same cycle produce one abort only.
//  ABORT: owner disconnected (its readies 0).
//    Drive cmd_o={I2C_CMD_STOP,28'h0}, cmd_valid_o=1.
//    Drain the controller: tx_valid_o=1 with tx_o=8'h00; rx_ready_o=1, rx data discarded.
//    On cmd handshake: pulse req_abort_o[g], set rr_ptr<=g+1, go IDLE.
//  EOT accepted in the same cycle as err_i: release wins, no abort.
//  err_i in IDLE or ABORT: ignored.
//  Owner dropping valid mid-session holds the grant (watchdog applies). Multi-command transactions (START..EOT) are never interleaved.
//  Mid-operation reset: immediate return to reset state. The controller is reset separately via its sw_rst.
// STRUCTURE
//  udma_i2c_pkg: I2C_CMD_* opcodes (shared with udma_i2c_control), arb_state_e {ST_IDLE, ST_GRANTED, ST_ABORT}.
//  Sub-module udma_i2c_rr_pick: combinational round-robin first-one finder (req vector, ptr) -> index, found.
//  Top: FSM, owner register, watchdog counter, muxes.
// TESTING
//  Req1 only sends START, WRB 0xA0, EOT -> grant_o=4'b0010 one cycle after valid; 3 cmds forwarded in order; grant 0 after EOT.
//  Req0 and Req2 valid, rr_ptr=0 -> req0 served first; req2 granted on the cycle after req0's EOT accept; then rr_ptr=3.
//  Req3 sends WR with rpt 2 and tx bytes 0x11,0x22 while req0 is valid -> both bytes reach tx_o; req0 blocked until req3's EOT.
//  TIMEOUT_CYC=16, owner silent after START -> STOP injected 16 cycles after the last handshake; req_abort_o pulses once; grant released.
//  err_i pulse while the controller waits for WR data -> tx 0x00 drained, STOP accepted, abort pulse, next requester granted.
//  rst_i asserted in GRANTED and in ABORT -> all outputs 0 the next cycle; rr_ptr=0; req0 wins the next arbitration.

Source files
------------

// File: rtl/udma_i2c_pkg.sv
// Shared I2C command opcodes (same encoding as udma_i2c_control) and arbiter state type.
package udma_i2c_pkg;

    localparam logic [3:0] I2C_CMD_START   = 4'h0;
    localparam logic [3:0] I2C_CMD_WAIT_EV = 4'h1;
    localparam logic [3:0] I2C_CMD_STOP    = 4'h2;
    localparam logic [3:0] I2C_CMD_RD_ACK  = 4'h4;
    localparam logic [3:0] I2C_CMD_RD_NACK = 4'h6;
    localparam logic [3:0] I2C_CMD_WRB     = 4'h7;
    localparam logic [3:0] I2C_CMD_WR      = 4'h8;
    localparam logic [3:0] I2C_CMD_EOT     = 4'h9;
    localparam logic [3:0] I2C_CMD_WAIT    = 4'hA;
    localparam logic [3:0] I2C_CMD_RPT     = 4'hC;
    localparam logic [3:0] I2C_CMD_CFG     = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_ABORT
    } arb_state_e;

    function automatic logic [3:0] cmd_opcode(input logic [31:0] cmd);
        return cmd[31:28];
    endfunction

endpackage

// File: rtl/udma_i2c_rr_pick.sv
// Combinational round-robin first-one finder: first set bit of req_i at or above
// ptr_i, wrapping around to index 0.
module udma_i2c_rr_pick #(
    parameter int NB_REQ = 4,
    parameter int PW     = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    output logic [PW-1:0]     idx_o,
    output logic              found_o
);

    logic [PW:0] pos;

    // Scan offsets from the far end down so the smallest offset from ptr_i wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr_i} + (PW + 1)'(i);
            if (pos >= (PW + 1)'(NB_REQ))
                pos = pos - (PW + 1)'(NB_REQ);
            if (req_i[pos[PW-1:0]]) begin
                idx_o   = pos[PW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udma_i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one udma_i2c_control cmd/tx/rx channel among NB_REQ
// requesters, with bus lock until EOT and a watchdog/error-driven STOP injection.
module udma_i2c_cmd_arbiter
    import udma_i2c_pkg::*;
#(
    parameter int NB_REQ      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic [NB_REQ-1:0][31:0] req_cmd_i,
    input  logic [NB_REQ-1:0]      req_cmd_valid_i,
    output logic [NB_REQ-1:0]      req_cmd_ready_o,
    input  logic [NB_REQ-1:0][7:0] req_tx_i,
    input  logic [NB_REQ-1:0]      req_tx_valid_i,
    output logic [NB_REQ-1:0]      req_tx_ready_o,
    output logic [7:0]             req_rx_o,
    output logic [NB_REQ-1:0]      req_rx_valid_o,
    input  logic [NB_REQ-1:0]      req_rx_ready_i,
    output logic [NB_REQ-1:0]      req_eot_o,
    output logic [NB_REQ-1:0]      req_abort_o,

    output logic [31:0]            cmd_o,
    output logic                   cmd_valid_o,
    input  logic                   cmd_ready_i,
    output logic [7:0]             tx_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic [7:0]             rx_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    input  logic                   eot_i,
    input  logic                   err_i,

    output logic [NB_REQ-1:0]      grant_o
);

    localparam int PW = $clog2(NB_REQ);
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
    localparam logic [WW-1:0] WD_TRIP = WW'(TIMEOUT_CYC - 2);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     owner_q, rr_ptr_q, owner_inc, pick_idx;
    logic              pick_found;
    logic [WW-1:0]     wd_cnt_q;
    logic [NB_REQ-1:0] owner_oh;

    logic granted, own_cmd_hs, own_tx_hs, own_rx_hs, own_any_hs;
    logic eot_accept, wd_inc, wd_trip;

    udma_i2c_rr_pick #(
        .NB_REQ (NB_REQ),
        .PW     (PW)
    ) u_rr_pick (
        .req_i   (req_cmd_valid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign owner_oh   = NB_REQ'(1) << owner_q;
    assign owner_inc  = (owner_q == PW'(NB_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign granted    = (state_q == ST_GRANTED);
    assign own_cmd_hs = granted & req_cmd_valid_i[owner_q] & cmd_ready_i;
    assign own_tx_hs  = granted & req_tx_valid_i[owner_q] & tx_ready_i;
    assign own_rx_hs  = granted & rx_valid_i & req_rx_ready_i[owner_q];
    assign own_any_hs = own_cmd_hs | own_tx_hs | own_rx_hs;
    assign eot_accept = own_cmd_hs & (cmd_opcode(req_cmd_i[owner_q]) == I2C_CMD_EOT);

    // Trip one count early so the STOP goes out exactly TIMEOUT_CYC cycles after
    // the owner's last handshake.
    assign wd_inc  = granted & cmd_ready_i & ~req_cmd_valid_i[owner_q];
    assign wd_trip = wd_inc & ~own_any_hs & (wd_cnt_q >= WD_TRIP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && pick_found)
                owner_q <= pick_idx;
            if (eot_accept || (state_q == ST_ABORT && cmd_ready_i))
                rr_ptr_q <= owner_inc;
            if (!granted || own_any_hs)
                wd_cnt_q <= '0;
            else if (wd_inc && wd_cnt_q != WD_LAST)
                wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_o         = '0;
        req_cmd_ready_o = '0;
        req_tx_ready_o  = '0;
        req_rx_o        = '0;
        req_rx_valid_o  = '0;
        req_eot_o       = '0;
        req_abort_o     = '0;
        cmd_o           = '0;
        cmd_valid_o     = 1'b0;
        tx_o            = '0;
        tx_valid_o      = 1'b0;
        rx_ready_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found)
                    state_d = ST_GRANTED;
            end
            ST_GRANTED: begin
                grant_o         = owner_oh;
                cmd_o           = req_cmd_i[owner_q];
                cmd_valid_o     = req_cmd_valid_i[owner_q];
                tx_o            = req_tx_i[owner_q];
                tx_valid_o      = req_tx_valid_i[owner_q];
                rx_ready_o      = req_rx_ready_i[owner_q];
                req_rx_o        = rx_i;
                req_cmd_ready_o = cmd_ready_i ? owner_oh : '0;
                req_tx_ready_o  = tx_ready_i  ? owner_oh : '0;
                req_rx_valid_o  = rx_valid_i  ? owner_oh : '0;
                req_eot_o       = eot_i       ? owner_oh : '0;
                // A release in the same cycle as an error takes precedence.
                if (eot_accept)
                    state_d = ST_IDLE;
                else if (err_i || wd_trip)
                    state_d = ST_ABORT;
            end
            ST_ABORT: begin
                // Owner is cut off; drain pending data and close the bus with STOP.
                grant_o     = owner_oh;
                cmd_o       = {I2C_CMD_STOP, 28'h0};
                cmd_valid_o = 1'b1;
                tx_valid_o  = 1'b1;
                rx_ready_o  = 1'b1;
                if (cmd_ready_i) begin
                    req_abort_o = owner_oh;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
// Directed bench for udma_i2c_cmd_arbiter: grant/forwarding, round-robin order,
// tx/rx routing, watchdog STOP injection, error abort and mid-session reset.
module tb_udma_i2c_cmd_arbiter;
    import udma_i2c_pkg::*;

    localparam int NB = 4;
    localparam int TO = 16;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NB-1:0][31:0] req_cmd_i;
    logic [NB-1:0]       req_cmd_valid_i;
    logic [NB-1:0]       req_cmd_ready_o;
    logic [NB-1:0][7:0]  req_tx_i;
    logic [NB-1:0]       req_tx_valid_i;
    logic [NB-1:0]       req_tx_ready_o;
    logic [7:0]          req_rx_o;
    logic [NB-1:0]       req_rx_valid_o;
    logic [NB-1:0]       req_rx_ready_i;
    logic [NB-1:0]       req_eot_o;
    logic [NB-1:0]       req_abort_o;
    logic [31:0]         cmd_o;
    logic                cmd_valid_o;
    logic                cmd_ready_i;
    logic [7:0]          tx_o;
    logic                tx_valid_o;
    logic                tx_ready_i;
    logic [7:0]          rx_i;
    logic                rx_valid_i;
    logic                rx_ready_o;
    logic                eot_i;
    logic                err_i;
    logic [NB-1:0]       grant_o;

    int n_chk = 0;
    int n_err = 0;

    udma_i2c_cmd_arbiter #(
        .NB_REQ      (NB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_cmd_i       (req_cmd_i),
        .req_cmd_valid_i (req_cmd_valid_i),
        .req_cmd_ready_o (req_cmd_ready_o),
        .req_tx_i        (req_tx_i),
        .req_tx_valid_i  (req_tx_valid_i),
        .req_tx_ready_o  (req_tx_ready_o),
        .req_rx_o        (req_rx_o),
        .req_rx_valid_o  (req_rx_valid_o),
        .req_rx_ready_i  (req_rx_ready_i),
        .req_eot_o       (req_eot_o),
        .req_abort_o     (req_abort_o),
        .cmd_o           (cmd_o),
        .cmd_valid_o     (cmd_valid_o),
        .cmd_ready_i     (cmd_ready_i),
        .tx_o            (tx_o),
        .tx_valid_o      (tx_valid_o),
        .tx_ready_i      (tx_ready_i),
        .rx_i            (rx_i),
        .rx_valid_i      (rx_valid_i),
        .rx_ready_o      (rx_ready_o),
        .eot_i           (eot_i),
        .err_i           (err_i),
        .grant_o         (grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] arg);
        return {op, 20'h0, arg};
    endfunction

    task automatic set_cmd(input int r, input logic [3:0] op, input logic [7:0] arg, input logic v);
        req_cmd_i[r]       = mk(op, arg);
        req_cmd_valid_i[r] = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},    32'(grant_o),     32'h0);
        check({tag, "_cmd_vld"},  32'(cmd_valid_o), 32'h0);
        check({tag, "_tx_vld"},   32'(tx_valid_o),  32'h0);
        check({tag, "_rx_rdy"},   32'(rx_ready_o),  32'h0);
    endtask

    initial begin
        rst_i           = 1'b1;
        req_cmd_i       = '0;
        req_cmd_valid_i = '0;
        req_tx_i        = '0;
        req_tx_valid_i  = '0;
        req_rx_ready_i  = '0;
        cmd_ready_i     = 1'b1;
        tx_ready_i      = 1'b0;
        rx_i            = '0;
        rx_valid_i      = 1'b0;
        eot_i           = 1'b0;
        err_i           = 1'b0;

        tick(); tick(); settle();
        check_idle_outputs("rst");

        // Req1 alone: START, WRB 0xA0, EOT
        tick(); rst_i = 1'b0; set_cmd(1, I2C_CMD_START, 8'h00, 1'b1); settle();
        check("s1_idle_noready", 32'(req_cmd_ready_o), 32'h0);
        tick(); settle();
        check("s1_grant", 32'(grant_o), 32'b0010);
        check("s1_start", cmd_o, mk(I2C_CMD_START, 8'h00));
        check("s1_ready", 32'(req_cmd_ready_o), 32'b0010);
        tick(); set_cmd(1, I2C_CMD_WRB, 8'hA0, 1'b1); settle();
        check("s1_wrb", cmd_o, mk(I2C_CMD_WRB, 8'hA0));
        tick(); set_cmd(1, I2C_CMD_EOT, 8'h00, 1'b1); eot_i = 1'b1; settle();
        check("s1_eot", cmd_o, mk(I2C_CMD_EOT, 8'h00));
        check("s1_eot_out", 32'(req_eot_o), 32'b0010);
        tick(); eot_i = 1'b0; set_cmd(1, I2C_CMD_START, 8'h00, 1'b0); settle();
        check("s1_release", 32'(grant_o), 32'h0);

        // Req0 and req2 from rr_ptr=0
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        set_cmd(0, I2C_CMD_START, 8'h00, 1'b1);
        set_cmd(2, I2C_CMD_START, 8'h02, 1'b1);
        tick(); settle();
        check("s2_grant0", 32'(grant_o), 32'b0001);
        check("s2_ready0", 32'(req_cmd_ready_o), 32'b0001);
        check("s2_cmd0", cmd_o, mk(I2C_CMD_START, 8'h00));
        tick(); set_cmd(0, I2C_CMD_EOT, 8'h00, 1'b1);
        tick(); set_cmd(0, I2C_CMD_START, 8'h00, 1'b0); settle();
        check("s2_gap", 32'(grant_o), 32'h0);
        tick(); settle();
        check("s2_grant2", 32'(grant_o), 32'b0100);
        check("s2_cmd2", cmd_o, mk(I2C_CMD_START, 8'h02));
        tick(); set_cmd(2, I2C_CMD_EOT, 8'h00, 1'b1);
        tick(); set_cmd(2, I2C_CMD_START, 8'h00, 1'b0);

        // Req3 (rr_ptr=3) wins over req0; RPT/WR with two tx bytes
        set_cmd(0, I2C_CMD_START, 8'h00, 1'b1);
        set_cmd(3, I2C_CMD_START, 8'h00, 1'b1);
        tick(); settle();
        check("s3_grant3", 32'(grant_o), 32'b1000);
        tick(); set_cmd(3, I2C_CMD_RPT, 8'd2, 1'b1); settle();
        check("s3_rpt", cmd_o, mk(I2C_CMD_RPT, 8'd2));
        tick(); set_cmd(3, I2C_CMD_WR, 8'h00, 1'b1);
        tick(); set_cmd(3, I2C_CMD_WR, 8'h00, 1'b0);
        req_tx_i[3] = 8'h11; req_tx_valid_i[3] = 1'b1; tx_ready_i = 1'b1; settle();
        check("s3_tx1", 32'(tx_o), 32'h11);
        check("s3_tx_ready", 32'(req_tx_ready_o), 32'b1000);
        check("s3_req0_blocked", 32'(req_cmd_ready_o), 32'b1000);
        tick(); req_tx_i[3] = 8'h22; settle();
        check("s3_tx2", 32'(tx_o), 32'h22);
        check("s3_tx2_vld", 32'(tx_valid_o), 32'h1);
        tick(); req_tx_valid_i[3] = 1'b0; tx_ready_i = 1'b0; set_cmd(3, I2C_CMD_EOT, 8'h00, 1'b1); settle();
        check("s3_eot", cmd_o, mk(I2C_CMD_EOT, 8'h00));
        tick(); set_cmd(3, I2C_CMD_START, 8'h00, 1'b0); settle();
        check("s3_release", 32'(grant_o), 32'h0);
        tick(); settle();
        check("s3_grant0", 32'(grant_o), 32'b0001);
        rx_i = 8'h5A; rx_valid_i = 1'b1; req_rx_ready_i = 4'b0001; settle();
        check("s3_rx_valid", 32'(req_rx_valid_o), 32'b0001);
        check("s3_rx_data", 32'(req_rx_o), 32'h5A);
        check("s3_rx_ready", 32'(rx_ready_o), 32'h1);
        tick(); rx_valid_i = 1'b0; req_rx_ready_i = '0; set_cmd(0, I2C_CMD_EOT, 8'h00, 1'b1);
        tick(); set_cmd(0, I2C_CMD_START, 8'h00, 1'b0);

        // Watchdog: req1 silent after START
        set_cmd(1, I2C_CMD_START, 8'h00, 1'b1);
        tick(); settle();
        check("s4_grant", 32'(grant_o), 32'b0010);
        tick(); set_cmd(1, I2C_CMD_START, 8'h00, 1'b0);
        for (int k = 1; k < TO; k++) begin
            settle();
            check("s4_wait", 32'(cmd_valid_o), 32'h0);
            tick();
        end
        settle();
        check("s4_stop_vld", 32'(cmd_valid_o), 32'h1);
        check("s4_stop", cmd_o, {I2C_CMD_STOP, 28'h0});
        check("s4_drain_vld", 32'(tx_valid_o), 32'h1);
        check("s4_drain_data", 32'(tx_o), 32'h0);
        check("s4_abort", 32'(req_abort_o), 32'b0010);
        check("s4_owner_cut", 32'(req_cmd_ready_o), 32'h0);
        tick(); settle();
        check("s4_abort_once", 32'(req_abort_o), 32'h0);
        check("s4_release", 32'(grant_o), 32'h0);

        // err_i while the controller waits for WR data (req2, rr_ptr=2)
        set_cmd(2, I2C_CMD_START, 8'h00, 1'b1);
        tick(); settle();
        check("s5_grant", 32'(grant_o), 32'b0100);
        tick(); set_cmd(2, I2C_CMD_WR, 8'h00, 1'b1);
        tick(); set_cmd(2, I2C_CMD_WR, 8'h00, 1'b0);
        cmd_ready_i = 1'b0; tx_ready_i = 1'b1; err_i = 1'b1; settle();
        check("s5_pre_err", 32'(tx_valid_o), 32'h0);
        tick(); err_i = 1'b0; settle();
        check("s5_stop", cmd_o, {I2C_CMD_STOP, 28'h0});
        check("s5_drain_vld", 32'(tx_valid_o), 32'h1);
        check("s5_drain_data", 32'(tx_o), 32'h0);
        check("s5_rx_drain", 32'(rx_ready_o), 32'h1);
        check("s5_no_abort_yet", 32'(req_abort_o), 32'h0);
        check("s5_owner_cut", 32'(req_tx_ready_o), 32'h0);
        tick(); cmd_ready_i = 1'b1; set_cmd(3, I2C_CMD_START, 8'h00, 1'b1); settle();
        check("s5_abort", 32'(req_abort_o), 32'b0100);
        tick(); tx_ready_i = 1'b0; settle();
        check("s5_idle", 32'(grant_o), 32'h0);
        tick(); settle();
        check("s5_next", 32'(grant_o), 32'b1000);

        // EOT accepted together with err_i: release, no abort
        tick(); set_cmd(3, I2C_CMD_EOT, 8'h00, 1'b1); err_i = 1'b1; settle();
        check("eot_err_no_abort", 32'(req_abort_o), 32'h0);
        tick(); err_i = 1'b0; set_cmd(3, I2C_CMD_START, 8'h00, 1'b0); settle();
        check("eot_err_release", 32'(grant_o), 32'h0);
        check("eot_err_no_stop", 32'(cmd_valid_o), 32'h0);
        err_i = 1'b1; tick(); err_i = 1'b0; settle();
        check("idle_err_ignored", 32'(cmd_valid_o), 32'h0);

        // Reset while GRANTED
        set_cmd(1, I2C_CMD_START, 8'h00, 1'b1);
        tick(); settle();
        check("s6_grant", 32'(grant_o), 32'b0010);
        rst_i = 1'b1; tick(); settle();
        check_idle_outputs("s6_rst_granted");
        rst_i = 1'b0; set_cmd(1, I2C_CMD_EOT, 8'h00, 1'b1);
        tick(); settle();
        check("s6_regrant", 32'(grant_o), 32'b0010);
        tick(); set_cmd(1, I2C_CMD_EOT, 8'h00, 1'b0);

        // Reset while ABORT (rr_ptr=2 beforehand)
        set_cmd(2, I2C_CMD_START, 8'h00, 1'b1); cmd_ready_i = 1'b0;
        tick(); err_i = 1'b1; settle();
        check("s6_grant2", 32'(grant_o), 32'b0100);
        tick(); err_i = 1'b0; settle();
        check("s6_in_abort", 32'(cmd_valid_o), 32'h1);
        rst_i = 1'b1; set_cmd(0, I2C_CMD_START, 8'h00, 1'b1);
        tick(); settle();
        check_idle_outputs("s6_rst_abort");
        rst_i = 1'b0; cmd_ready_i = 1'b1;
        tick(); settle();
        check("s6_rr_reset", 32'(grant_o), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
